// File: rtl/range_counter_ctrl_pkg.sv
// Shared definitions for the range counter controller: FSM state encoding
// and the default counter width / bounds.
package range_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_W      = 6;
    localparam int DEF_LO_RST = 10;
    localparam int DEF_HI_RST = 40;

endpackage

// File: rtl/range_counter_ctrl_core.sv
// Counting datapath: the W-bit counter register, the bound comparisons and
// the terminal-count flag. The controller decides each edge whether to
// clear, load the lower bound, increment, or hold.
module range_count_core #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] count,
    output logic         at_hi,
    output logic         out_of_range,
    output logic         term
);

    // Counter register: clear beats load beats increment; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= lo;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // Unsigned bound compares; term only means something while running.
    always_comb begin
        at_hi        = (count == hi);
        out_of_range = (count < lo) || (count > hi);
        term         = run && at_hi;
    end

endmodule

// File: rtl/range_counter_ctrl.sv
// Sequencer around a bounded up-counter. Holds the runtime range
// configuration (lo, hi, one-shot) and walks the counter through
// IDLE / RUN / PAUSE / DONE.
//
// Configuration handshake: a transfer happens on every rising edge where
// cfg_valid && cfg_ready; cfg_ready is high only in IDLE or DONE. An offer
// with cfg_lo > cfg_hi is consumed but discarded, and cfg_err pulses for
// the following cycle.
module range_counter_ctrl
    import range_counter_ctrl_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int LO_RST = DEF_LO_RST,
    parameter int HI_RST = DEF_HI_RST
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_lo,
    input  logic [W-1:0] cfg_hi,
    input  logic         cfg_oneshot,
    output logic         cfg_err,
    input  logic         start,
    input  logic         stop,
    input  logic         abort,
    output logic [W-1:0] count,
    output logic         term,
    output logic         done,
    output logic         busy,
    output logic [1:0]   state_dbg
);

    state_t       state;
    state_t       next_state;
    logic [W-1:0] lo_q;
    logic [W-1:0] hi_q;
    logic         oneshot_q;
    logic         cfg_err_q;
    logic         done_q;

    logic         cfg_take;
    logic         cfg_legal;
    logic         cfg_load;
    logic [W-1:0] lo_eff;

    logic         core_load;
    logic         core_inc;
    logic         core_clear;
    logic         at_hi;
    logic         out_of_range;

    // Decode the configuration transfer. When a legal transfer coincides
    // with start, the freshly offered lo is the start value.
    always_comb begin
        cfg_take  = cfg_valid && cfg_ready;
        cfg_legal = (cfg_lo <= cfg_hi);
        cfg_load  = cfg_take && cfg_legal;
        lo_eff    = cfg_load ? cfg_lo : lo_q;
    end

    range_count_core #(
        .W(W)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .load         (core_load),
        .inc          (core_inc),
        .clear        (core_clear),
        .run          (state == ST_RUN),
        .lo           (lo_eff),
        .hi           (hi_q),
        .count        (count),
        .at_hi        (at_hi),
        .out_of_range (out_of_range),
        .term         (term)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; abort beats stop beats start in every state.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !stop) next_state = ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        next_state = ST_PAUSE;
                    end else if (!out_of_range && at_hi && oneshot_q) begin
                        next_state = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) next_state = ST_RUN;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: per-edge commands for the counting core.
    always_comb begin
        core_load  = 1'b0;
        core_inc   = 1'b0;
        core_clear = 1'b0;
        if (abort) begin
            core_clear = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    core_load = start && !stop;
                end
                ST_RUN: begin
                    if (!stop) begin
                        if (out_of_range) begin
                            core_load = 1'b1;
                        end else if (at_hi) begin
                            core_load = !oneshot_q;
                        end else begin
                            core_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    core_load = 1'b0;
                end
            endcase
        end
    end

    // Configuration registers, error pulse and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q      <= LO_RST[W-1:0];
            hi_q      <= HI_RST[W-1:0];
            oneshot_q <= 1'b0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (cfg_load) begin
                lo_q      <= cfg_lo;
                hi_q      <= cfg_hi;
                oneshot_q <= cfg_oneshot;
            end
            cfg_err_q <= cfg_take && !cfg_legal;
            done_q    <= (state == ST_RUN) && (next_state == ST_DONE);
        end
    end

    assign cfg_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_PAUSE);
    assign cfg_err   = cfg_err_q;
    assign done      = done_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_range_counter_ctrl.sv
// Bench for range_counter_ctrl: directed test-plan steps followed by a
// randomized phase, all checked against a behavioural model of the
// sequencer kept in this file.
module tb_range_counter_ctrl;

    localparam int W = 6;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_lo;
    logic [W-1:0] cfg_hi;
    logic         cfg_oneshot;
    logic         cfg_err;
    logic         start;
    logic         stop;
    logic         abort;
    logic [W-1:0] count;
    logic         term;
    logic         done;
    logic         busy;
    logic [1:0]   state_dbg;

    range_counter_ctrl #(.W(W), .LO_RST(10), .HI_RST(40)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_lo      (cfg_lo),
        .cfg_hi      (cfg_hi),
        .cfg_oneshot (cfg_oneshot),
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .abort       (abort),
        .count       (count),
        .term        (term),
        .done        (done),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    int compared   = 0;
    int mismatched = 0;

    // ---------------- reference model ----------------
    int m_st, m_count, m_lo, m_hi, m_one, m_err, m_done;

    task automatic model_reset();
        m_st = M_IDLE; m_count = 0; m_lo = 10; m_hi = 40;
        m_one = 0; m_err = 0; m_done = 0;
    endtask

    // One rising edge of the specified behaviour, using the current inputs.
    task automatic model_edge();
        int take, legal, n_lo, n_hi, n_one;
        take  = (cfg_valid && (m_st == M_IDLE || m_st == M_DONE)) ? 1 : 0;
        legal = (int'(cfg_lo) <= int'(cfg_hi)) ? 1 : 0;
        n_lo  = (take && legal) ? int'(cfg_lo) : m_lo;
        n_hi  = (take && legal) ? int'(cfg_hi) : m_hi;
        n_one = (take && legal) ? int'(cfg_oneshot) : m_one;
        m_err  = (take && !legal) ? 1 : 0;
        m_done = 0;
        if (abort) begin
            m_st = M_IDLE; m_count = 0;
        end else if (m_st == M_IDLE || m_st == M_DONE) begin
            if (start && !stop) begin m_st = M_RUN; m_count = n_lo; end
        end else if (m_st == M_RUN) begin
            if (stop) m_st = M_PAUSE;
            else if (m_count < m_lo || m_count > m_hi) m_count = m_lo;
            else if (m_count == m_hi) begin
                if (m_one != 0) begin m_st = M_DONE; m_done = 1; end
                else m_count = m_lo;
            end else m_count = m_count + 1;
        end else begin
            if (start && !stop) m_st = M_RUN;
        end
        m_lo = n_lo; m_hi = n_hi; m_one = n_one;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",     32'(count),     32'(m_count));
        chk("state",     32'(state_dbg), 32'(m_st));
        chk("term",      32'(term),      32'((m_st == M_RUN && m_count == m_hi) ? 1 : 0));
        chk("busy",      32'(busy),      32'((m_st == M_RUN || m_st == M_PAUSE) ? 1 : 0));
        chk("cfg_ready", 32'(cfg_ready), 32'((m_st == M_IDLE || m_st == M_DONE) ? 1 : 0));
        chk("done",      32'(done),      32'(m_done));
        chk("cfg_err",   32'(cfg_err),   32'(m_err));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        cfg_valid = 0; start = 0; stop = 0; abort = 0;
    endtask

    task automatic pulse_start();
        start = 1; cyc(); start = 0;
    endtask

    task automatic configure(input int lo, input int hi, input int one);
        cfg_valid = 1; cfg_lo = W'(lo); cfg_hi = W'(hi); cfg_oneshot = one[0];
        cyc();
        cfg_valid = 0;
    endtask

    task automatic run_until(input int val);
        int n = 0;
        while (int'(count) != val && n < 200) begin cyc(); n++; end
        chk("reach_count", 32'(count), 32'(val));
    endtask

    initial begin
        rst = 1; cfg_lo = 0; cfg_hi = 0; cfg_oneshot = 0;
        idle_inputs();
        model_reset();
        #12;
        check_all();
        rst = 0;

        // Defaults: count 10..40 then wraps to 10, period 31.
        pulse_start();
        chk("start_lo", 32'(count), 32'd10);
        for (int i = 0; i < 30; i++) cyc();
        chk("at_hi_count", 32'(count), 32'd40);
        chk("at_hi_term", 32'(term), 32'd1);
        cyc();
        chk("wrap_count", 32'(count), 32'd10);
        abort = 1; cyc(); abort = 0;

        // One-shot 3..5.
        configure(3, 5, 1);
        pulse_start();
        chk("os_first", 32'(count), 32'd3);
        cyc(); cyc(); cyc();
        chk("os_done", 32'(done), 32'd1);
        chk("os_hold", 32'(count), 32'd5);
        cyc();
        chk("os_done_once", 32'(done), 32'd0);

        // Restore defaults from DONE, then an illegal offer in IDLE.
        configure(10, 40, 0);
        abort = 1; cyc(); abort = 0;
        configure(20, 7, 0);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        cyc();
        chk("err_gone", 32'(cfg_err), 32'd0);

        // Pause at 15 for four cycles, then resume.
        pulse_start();
        chk("bounds_kept", 32'(count), 32'd10);
        run_until(15);
        stop = 1;
        for (int i = 0; i < 4; i++) cyc();
        stop = 0;
        chk("paused", 32'(count), 32'd15);
        pulse_start();
        cyc();
        chk("resume", 32'(count), 32'd16);

        // stop + abort together at 22.
        run_until(22);
        stop = 1; abort = 1; cyc(); stop = 0; abort = 0;
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_state", 32'(state_dbg), 32'(M_IDLE));

        // start + stop together in RUN -> PAUSE.
        pulse_start();
        cyc();
        start = 1; stop = 1; cyc(); start = 0; stop = 0;
        chk("start_stop", 32'(state_dbg), 32'(M_PAUSE));
        pulse_start();

        // Asynchronous reset between edges at count 33.
        configure(0, 0, 0);
        run_until(33);
        #3 rst = 1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_state", 32'(state_dbg), 32'(M_IDLE));
        model_reset();
        @(negedge clk);
        rst = 0;
        pulse_start();
        chk("arst_lo", 32'(count), 32'd10);

        // Boundary: hi = 63 wrapping, and lo == hi.
        abort = 1; cyc(); abort = 0;
        configure(60, 63, 0);
        pulse_start();
        for (int i = 0; i < 6; i++) cyc();
        abort = 1; cyc(); abort = 0;
        configure(7, 7, 0);
        pulse_start();
        for (int i = 0; i < 3; i++) cyc();

        // Randomized phase.
        for (int i = 0; i < 800; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 14) == 0);
            abort     = ($urandom_range(0, 59) == 0);
            cfg_valid = ($urandom_range(0, 4) == 0);
            cfg_lo    = W'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) cfg_hi = W'($urandom_range(0, 63));
            else if ($urandom_range(0, 5) == 0) cfg_hi = 6'd63;
            else cfg_hi = W'($urandom_range(63, int'(cfg_lo)) < int'(cfg_lo) + 12
                             ? $urandom_range(63, int'(cfg_lo))
                             : int'(cfg_lo) + $urandom_range(0, 11));
            cfg_oneshot = $urandom_range(0, 1) == 1;
            cyc();
        end
        idle_inputs();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
